alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one combinational ALU instance between NUM_REQ requesters, e.g. the EX-stage operand path and the branch/address-generation path.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin. Each result is registered into that requester's response slot, giving 1-cycle latency with full throughput per requester.

Parameters:
- DATA_WIDTH, 32, operand/result width passed to the ALU.
- NUM_REQ, 2, number of requesters (2..8).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester grant; request accepted when valid&ready.
- req_op  input  NUM_REQ x alu_operation_type  ALU operation per requester.
- req_a  input  NUM_REQ x DATA_WIDTH  operand A per requester.
- req_b  input  NUM_REQ x DATA_WIDTH  operand B per requester.
- rsp_valid  output  NUM_REQ  response slot holds a result.
- rsp_ready  input  NUM_REQ  requester consumes the response.
- rsp_result  output  NUM_REQ x DATA_WIDTH  registered ALU result.
- rsp_zero  output  NUM_REQ  registered ALU zero flag.

Behaviour:
- Single clock domain. Reset is synchronous and active-low, sampled on rising clk edge.
- Reset values: rsp_valid=0, rsp_result=0, rsp_zero=0, rr_ptr=0.
- req_ready is forced to 0 while rst_n=0.
- Eligibility: eligible[i] = req_valid[i] & (!rsp_valid[i] | rsp_ready[i]). A full slot being drained in the same cycle counts as free.
- Grant: at most one grant per cycle. Choose the first eligible index searching from rr_ptr upward, wrapping modulo NUM_REQ.
- req_ready[i]=1 only for the granted index. It is combinational and may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- ALU mux: the granted requester's op/a/b drive the ALU inputs. With no grant, the ALU inputs are driven to 0, op=ADD, and the outputs are ignored.
- Pointer update: on a grant to index g, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Response slot i, by priority:
  - grant to i: rsp_valid[i]<=1 and rsp_result/rsp_zero <= ALU outputs. This also covers a simultaneous drain and refill.
  - else if rsp_ready[i]: rsp_valid[i]<=0, and result/zero hold their last value.
  - else: hold.
- Latency: a request accepted at cycle N gives rsp_valid at cycle N+1. Sustained 1 result/cycle per requester is possible when rsp_ready=1.
- Aggregate throughput is 1 op/cycle across all requesters.
- Backpressure: while rsp_valid[i]=1 and rsp_ready[i]=0, requester i is ineligible. Other requesters continue to be served.
- Stability: rsp_result/rsp_zero are stable while rsp_valid=1 and rsp_ready=0.
- ALU semantics are inherited unchanged:
  - Unknown op gives result 0, zero=1.
  - LUI gives B<<12, truncated to DATA_WIDTH.
  - Shifts use the full B value.
  - zero=1 iff result==0.
- Fairness: any continuously valid requester is granted within NUM_REQ cycles, provided its slot drains.
- Reset mid-operation: pending responses are discarded, with no partial state retained. The first grant after reset goes to the lowest-index eligible requester.
- rsp_ready while rsp_valid=0 is ignored.

Decomposition:
- Package common gains:
  - constant ALU_REQ_MAX = 8.
  - typedef alu_req_t (packed struct: op of alu_operation_type, a, b).
  - typedef alu_rsp_t (packed struct: result, zero).
- alu_operation_type stays in common.
- Sub-module rr_arbiter (parameter N): inputs req[N], advance, clk, rst_n; outputs grant[N] one-hot and rr_ptr.
- alu_arbiter instantiates rr_arbiter, the existing ALU, and NUM_REQ response registers.

Test Plan:
- Single request: req0 ADD a=5, b=7, rsp_ready=1. Expect req_ready[0]=1 at cycle N, then rsp_valid[0]=1, result=12, zero=0 at N+1.
- Contention: both valid at cycle N after reset, req0 SUB 9-9, req1 XOR 0xF0^0x0F.
  - N: grant req0.
  - N+1: rsp0 result=0, zero=1; grant req1.
  - N+2: rsp1 result=0xFF.
  - Thereafter grants alternate 0,1,0,1.
- Backpressure: rsp_ready[0]=0 with rsp0 full for 3 cycles while req0 and req1 stay valid.
  - req_ready[0]=0 throughout.
  - req1 is granted every cycle.
  - rsp0 value is stable.
  - When rsp_ready[0] rises, req0 is granted in the same cycle.
- Back-to-back: req0 valid for 4 cycles with LUI b=0x12345, SLL 1<<4, AND 0xFF&0x0F, unknown op, req1 idle. Expect results 0x12345000, 0x10, 0x0F, 0 (zero=1) on consecutive cycles.
- Reset mid-operation: rsp_valid[1]=1 and rr_ptr=1, then assert rst_n=0 for 1 cycle.
  - During reset: req_ready=0.
  - After reset: rsp_valid=0 and rsp_result=0.
  - Both requesting: grant goes to req0 first.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter slice.
//   alu_operation_type : ALU opcode, encodings 11..15 are unassigned (ALU returns 0).
//   alu_req_t / alu_rsp_t : request/response bundles at the default datapath width.
//   ALU_REQ_MAX : upper bound on the number of requesters sharing one ALU.
package alu_arbiter_pkg;

    localparam int unsigned ALU_REQ_MAX    = 8;
    localparam int unsigned ALU_DATA_WIDTH = 32;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluSll  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluSlt  = 4'd8,
        AluSltu = 4'd9,
        AluLui  = 4'd10
    } alu_operation_type;

    typedef struct packed {
        alu_operation_type         op;
        logic [ALU_DATA_WIDTH-1:0] a;
        logic [ALU_DATA_WIDTH-1:0] b;
    } alu_req_t;

    typedef struct packed {
        logic [ALU_DATA_WIDTH-1:0] result;
        logic                      zero;
    } alu_rsp_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU.
//   op_i, a_i, b_i : operation and operands
//   result_o       : result, 0 for unassigned opcodes
//   zero_o         : high iff result_o is zero
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  alu_operation_type       op_i,
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    output logic [DATA_WIDTH-1:0]   result_o,
    output logic                    zero_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            AluAdd:  result_o = a_i + b_i;
            AluSub:  result_o = a_i - b_i;
            AluAnd:  result_o = a_i & b_i;
            AluOr:   result_o = a_i | b_i;
            AluXor:  result_o = a_i ^ b_i;
            // Shift amounts are the whole B operand, so B >= DATA_WIDTH flushes the value.
            AluSll:  result_o = a_i << b_i;
            AluSrl:  result_o = a_i >> b_i;
            AluSra:  result_o = $signed(a_i) >>> b_i;
            AluSlt:  result_o = DATA_WIDTH'($signed(a_i) < $signed(b_i));
            AluSltu: result_o = DATA_WIDTH'(a_i < b_i);
            AluLui:  result_o = b_i << 12;
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
//   req_i     : per-index request
//   advance_i : the current grant was taken; move the pointer past the winner
//   grant_o   : one-hot grant (or zero), first request at or above rr_ptr_o, wrapping
//   rr_ptr_o  : highest-priority index for the current cycle
module rr_arbiter #(
    parameter int unsigned N    = 2,
    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N-1:0]    req_i,
    input  logic            advance_i,
    output logic [N-1:0]    grant_o,
    output logic [PtrW-1:0] rr_ptr_o
);

    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] win_idx;
    logic            found;

    always_comb begin
        int unsigned idx;
        idx     = 0;
        grant_o = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                win_idx      = PtrW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && found) begin
            ptr_d = (win_idx == PtrW'(N - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign rr_ptr_o = ptr_q;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters with round-robin arbitration.
//   req_valid_i/req_ready_o       : request handshake, ready is the combinational grant
//   req_op_i, req_a_i, req_b_i    : per-requester operation and operands
//   rsp_valid_o/rsp_ready_i       : response handshake per requester slot
//   rsp_result_o, rsp_zero_o      : registered ALU outputs, held while not drained
// A granted request produces its response one cycle later.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    input  alu_operation_type [NUM_REQ-1:0]     req_op_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_a_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_b_i,
    output logic [NUM_REQ-1:0]                  rsp_valid_o,
    input  logic [NUM_REQ-1:0]                  rsp_ready_i,
    output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  rsp_result_o,
    output logic [NUM_REQ-1:0]                  rsp_zero_o
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > ALU_REQ_MAX) begin : gen_param_check
        $error("alu_arbiter: NUM_REQ out of range");
    end

    logic [NUM_REQ-1:0]                 eligible;
    logic [NUM_REQ-1:0]                 grant;
    logic [PtrW-1:0]                    rr_ptr;
    logic                               advance;

    alu_operation_type                  alu_op;
    logic [DATA_WIDTH-1:0]              alu_a, alu_b, alu_result;
    logic                               alu_zero;

    logic [NUM_REQ-1:0]                 rsp_valid_q;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rsp_result_q;
    logic [NUM_REQ-1:0]                 rsp_zero_q;

    // A full slot that is being drained this cycle can be refilled in the same cycle.
    assign eligible    = req_valid_i & (~rsp_valid_q | rsp_ready_i);
    assign req_ready_o = grant & {NUM_REQ{rst_ni}};
    assign advance     = |(req_valid_i & req_ready_o);

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (eligible),
        .advance_i (advance),
        .grant_o   (grant),
        .rr_ptr_o  (rr_ptr)
    );

    // Idle ALU inputs are parked at ADD 0+0 to avoid needless toggling.
    always_comb begin
        alu_op = AluAdd;
        alu_a  = '0;
        alu_b  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                alu_op = req_op_i[i];
                alu_a  = req_a_i[i];
                alu_b  = req_b_i[i];
            end
        end
    end

    alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .op_i     (alu_op),
        .a_i      (alu_a),
        .b_i      (alu_b),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    rsp_valid_q[i]  <= 1'b1;
                    rsp_result_q[i] <= alu_result;
                    rsp_zero_q[i]   <= alu_zero;
                end else if (rsp_ready_i[i]) begin
                    rsp_valid_q[i]  <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_zero_o   = rsp_zero_q;

`ifndef SYNTHESIS
    a_grant_onehot: assert property (@(posedge clk_i) $onehot0(grant));
    a_ptr_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        32'(rr_ptr) < NUM_REQ);
`endif

endmodule
